// File: rtl/instr_mem_responder.sv
// Round-robin arbiter that serves instruction fetches from several CPUs out of one
// synchronous-read ROM port and steers each returned word back to its requester.
module instr_mem_responder #(
  parameter int unsigned nCPUs     = 3,
  parameter int unsigned addrWidth = 6
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [nCPUs-1:0]            imReq,
  input  logic [nCPUs-1:0][31:0]      imAddr,
  output logic [nCPUs-1:0]            imGnt,
  output logic [nCPUs-1:0]            imRspValid,
  output logic [nCPUs-1:0][31:0]      imRspData,
  output logic                        memEn,
  output logic [addrWidth-1:0]        memAddr,
  input  logic [31:0]                 memData
);

  localparam int unsigned IdxW = (nCPUs > 1) ? $clog2(nCPUs) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(nCPUs - 1);

  logic [IdxW-1:0]        prio_q, prio_d;
  logic                   rsp_pend_q, rsp_pend_d;
  logic [IdxW-1:0]        rsp_idx_q, rsp_idx_d;
  logic [nCPUs-1:0][31:0] rsp_data_q, rsp_data_d;

  logic                   gnt_found;
  logic [IdxW-1:0]        gnt_idx;
  logic                   gnt_live;

  // Search starts at prio_q and wraps; the first requester seen wins.
  always_comb begin
    logic [IdxW-1:0] cand;
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = prio_q;
    for (int unsigned k = 0; k < nCPUs; k++) begin
      if (!gnt_found && imReq[cand]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand;
      end
      cand = (cand == LastIdx) ? '0 : cand + 1'b1;
    end
  end

  // Grants are suppressed combinationally while reset is held.
  assign gnt_live = gnt_found & rst;

  always_comb begin
    imGnt = '0;
    for (int unsigned i = 0; i < nCPUs; i++) begin
      imGnt[i] = gnt_live && (gnt_idx == IdxW'(i));
    end
  end

  assign memEn   = gnt_live;
  assign memAddr = gnt_live ? imAddr[gnt_idx][addrWidth+1:2] : '0;

  always_comb begin
    prio_d     = prio_q;
    rsp_pend_d = gnt_found;
    rsp_idx_d  = rsp_idx_q;
    rsp_data_d = rsp_data_q;
    if (gnt_found) begin
      rsp_idx_d = gnt_idx;
      prio_d    = (gnt_idx == LastIdx) ? '0 : gnt_idx + 1'b1;
    end
    if (rsp_pend_q) begin
      rsp_data_d[rsp_idx_q] = memData;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prio_q     <= '0;
      rsp_pend_q <= 1'b0;
      rsp_idx_q  <= '0;
      rsp_data_q <= '0;
    end else begin
      prio_q     <= prio_d;
      rsp_pend_q <= rsp_pend_d;
      rsp_idx_q  <= rsp_idx_d;
      rsp_data_q <= rsp_data_d;
    end
  end

  // The ROM word is only on memData during the response cycle; afterwards the
  // captured copy keeps the stalled CPU's instruction stable.
  always_comb begin
    imRspValid = '0;
    imRspData  = rsp_data_q;
    for (int unsigned i = 0; i < nCPUs; i++) begin
      if (rsp_pend_q && (rsp_idx_q == IdxW'(i))) begin
        imRspValid[i] = 1'b1;
        imRspData[i]  = memData;
      end
    end
  end

endmodule

// File: doc/instr_mem_responder.md
# instr_mem_responder

Serving end of the shared instruction-fetch interface in `cpu_cluster`. It accepts fetch requests from `nCPUs` single-cycle CPUs and arbitrates them round-robin onto one synchronous-read instruction ROM port. It routes each returned word back to the requesting CPU one cycle after grant. CPUs stall while their request is pending.

## Interface
Parameters:
- `nCPUs`, 3: number of requesting CPUs (≥ 1).
- `addrWidth`, 6: ROM word-address width; the ROM holds 2^addrWidth words.

Ports:
- `clk`  input  1  clock; all state updates on the rising edge.
- `rst`  input  1  reset, asynchronous, active-low (0 = reset asserted).
- `imReq`  input  [nCPUs-1:0]  per-CPU fetch request.
- `imAddr`  input  [nCPUs-1:0][31:0]  per-CPU byte address; held stable while `imReq` is 1 and `imGnt` is 0.
- `imGnt`  output  [nCPUs-1:0]  one-hot or zero; the request is accepted this cycle.
- `imRspValid`  output  [nCPUs-1:0]  registered; instruction word valid for this CPU.
- `imRspData`  output  [nCPUs-1:0][31:0]  registered per-CPU instruction word.
- `memEn`  output  1  ROM read enable (= `|imGnt`).
- `memAddr`  output  [addrWidth-1:0]  ROM word address = granted `imAddr[addrWidth+1:2]`, otherwise 0.
- `memData`  input  32  ROM read data; valid the cycle after `memEn`.

## Operation
- Arbitration is combinational over `imReq`, using a round-robin priority pointer `prio` (log2 nCPUs bits).
  - The search starts at index `prio` and wraps modulo nCPUs.
  - The first requester found gets `imGnt`.
  - At most one grant is issued per cycle.
- Pointer update: after a grant to index g, `prio` <= (g+1) mod nCPUs. With no grant, `prio` holds.
- Response pipeline stage:
  - On grant, register `rspIdx` <= g and `rspPend` <= 1. Otherwise `rspPend` <= 0.
  - In the next cycle, `imRspValid[rspIdx]` = `rspPend` and `imRspData[rspIdx]` <= `memData`.
- `imRspData[i]` holds its last value until the next response to CPU i. Each CPU therefore sees a stable instruction while it stalls.
- Address bits [1:0] and bits above addrWidth+1 are ignored; no alignment check is made.
- A CPU may assert `imReq` in the same cycle its previous response arrives. Back-to-back fetches from one CPU are therefore possible every cycle when the other CPUs are idle.
- Identical addresses from different CPUs are served as separate grants. No merging is done.
- Reset (asynchronous, `rst`=0):
  - `prio`=0, `rspPend`=0, `rspIdx`=0, all `imRspValid`=0, all `imRspData`=0.
  - `imGnt`, `memEn` and `memAddr` are forced to 0 while in reset.
  - An in-flight response is dropped; it is not delivered after reset release.

## Timing
- Request-to-grant: same cycle if the CPU wins arbitration. Worst case is nCPUs-1 cycles of wait under full load.
- Grant-to-response: exactly 1 cycle (`imRspValid` in cycle N+1 for grant in cycle N).
- Throughput: 1 fetch per cycle aggregate.
  - Under continuous requests from all CPUs, each CPU gets 1 fetch per nCPUs cycles.
  - Grant order is 0,1,2,0,… starting from reset.
- The first cycle after `rst` deasserts: `prio`=0, so CPU 0 wins any tie.

## Test plan
- **Single requester:** CPU 1 only, `imAddr`=0x30, ROM word 12 = 0x00a00513.
  - Cycle N: `imGnt`=3'b010, `memAddr`=12.
  - Cycle N+1: `imRspValid`=3'b010, `imRspData[1]`=0x00a00513.
- **Full contention:** all three CPUs request continuously from reset.
  - Grants go 001,010,100,001,… in consecutive cycles.
  - Each response arrives one cycle after its grant with the correct word.
- **Pointer wrap:** grant to CPU 2, then CPUs 0 and 2 both request. CPU 0 is granted first, then CPU 2.
- **Same address:** CPUs 0 and 1 both fetch 0x0.
  - Two grants in consecutive cycles.
  - Both receive ROM word 0; `imRspData[2]` is unchanged.
- **Idle hold:** CPU 0 gets a response, then has no requests for 5 cycles.
  - `imRspValid[0]`=0 throughout.
  - `imRspData[0]` holds its value.
- **Reset mid-operation:** assert `rst`=0 in the cycle after a grant to CPU 2.
  - `imRspValid` is 0 immediately (asynchronous) and no late response appears.
  - After release, CPU 0 wins a 3-way tie.
